// File: rtl/fetch_pkg.sv
// Shared types for the fetch/decode instruction buffer.
// The entry layout is fixed at the package data width.
package fetch_pkg;

    localparam int unsigned FETCH_DATA_WIDTH = 32;
    localparam int unsigned FETCH_DEPTH      = 4;
    localparam int unsigned PTR_W            = $clog2(FETCH_DEPTH);

    typedef struct packed {
        logic [FETCH_DATA_WIDTH-1:0] instr;
        logic [FETCH_DATA_WIDTH-1:0] pc;
        logic [FETCH_DATA_WIDTH-1:0] pc_plus4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry circular FIFO between fetch and decode with valid/ready on both sides
// and a synchronous flush for redirects.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FETCH_DATA_WIDTH,
    parameter int unsigned DEPTH      = FETCH_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_instr,
    input  logic [DATA_WIDTH-1:0]        in_pc,
    input  logic [DATA_WIDTH-1:0]        in_pc_plus4,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_instr,
    output logic [DATA_WIDTH-1:0]        out_pc,
    output logic [DATA_WIDTH-1:0]        out_pc_plus4,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_depth_check
        $fatal(1, "fetch_queue: DEPTH must be a power of two and at least 2");
    end
    // The entry struct is sized by the package, so the instance width must agree.
    if (DATA_WIDTH != FETCH_DATA_WIDTH) begin : gen_width_check
        $fatal(1, "fetch_queue: DATA_WIDTH must equal fetch_pkg::FETCH_DATA_WIDTH");
    end

    fetch_entry_t        mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                enq;
    logic                deq;
    fetch_entry_t        head;

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign enq       = in_valid && in_ready && !flush;
    assign deq       = out_valid && out_ready && !flush;

    // Empty queue drives zeros so decode never sees stale storage.
    always_comb begin
        head = '0;
        if (out_valid) begin
            head = mem[rd_ptr];
        end
    end

    assign out_instr    = head.instr;
    assign out_pc       = head.pc;
    assign out_pc_plus4 = head.pc_plus4;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                mem[wr_ptr] <= '{instr: in_instr, pc: in_pc, pc_plus4: in_pc_plus4};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (enq && !deq) begin
                count <= count + CW'(1);
            end else if (deq && !enq) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction buffer between the fetch and decode stages, replacing the single-entry fetch/decode register with a DEPTH-entry FIFO. Each entry holds the fetched instruction word, its PC and PC+4. It uses a valid/ready handshake on both sides and supports a synchronous flush for redirects. This lets fetch run ahead of a stalled decode without losing instructions.

## Interface

Parameters:
- DATA_WIDTH, 32, width of instruction, PC and PC+4 fields
- DEPTH, 4, number of entries; power of two, ≥ 2

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset; empties queue
- flush  in  1  synchronous redirect; empties queue, discards same-cycle enqueue
- in_valid  in  1  fetch presents a valid entry
- in_ready  out  1  queue can accept an entry this cycle
- in_instr  in  DATA_WIDTH  fetched instruction word
- in_pc  in  DATA_WIDTH  PC of instruction
- in_pc_plus4  in  DATA_WIDTH  PC+4 of instruction
- out_valid  out  1  head entry valid for decode
- out_ready  in  1  decode accepts head entry (low = stall)
- out_instr  out  DATA_WIDTH  head instruction
- out_pc  out  DATA_WIDTH  head PC
- out_pc_plus4  out  DATA_WIDTH  head PC+4
- count  out  $clog2(DEPTH+1)  number of occupied entries

## Operation

- Enqueue fires when in_valid && in_ready && !flush. Dequeue fires when out_valid && out_ready && !flush.
- in_ready = (count != DEPTH). It is a function of registered state only, with no combinational path from out_ready.
- out_valid = (count != 0). out_* = head entry when out_valid, otherwise all-zero; empty-queue outputs are deterministic.
- Storage is circular, with write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits. Pointers wrap modulo DEPTH by natural overflow.
- Count update:
  - +1 on enqueue only
  - −1 on dequeue only
  - unchanged on both or neither
- Simultaneous enqueue and dequeue:
  - When full, in_ready is low, so only the dequeue happens.
  - When empty, out_valid is low, so only the enqueue happens. There is no same-cycle bypass.
- Priority: rst > flush > enqueue/dequeue.
  - flush sets wr_ptr = rd_ptr = 0 and count = 0.
  - Entry storage contents need not be cleared.
- FIFO order is strict. Entries are never reordered or duplicated.

## Timing

- Reset values: in_ready=1, out_valid=0, out_instr=out_pc=out_pc_plus4=0, count=0.
- Enqueue-to-output latency: an entry written at edge N appears on out_* with out_valid=1 in the cycle after edge N.
- Dequeue takes effect at the edge. The next entry (or zeros if empty) appears in the following cycle.
- Full throughput: with in_valid and out_ready held high, one entry per cycle passes through at steady state.
- A stall (out_ready low) holds out_* stable until the dequeue fires.
- flush or rst asserted at edge N: in the cycle after N, out_valid=0, count=0 and in_ready=1, regardless of same-cycle handshakes.
- rst held over multiple cycles keeps these values. The first enqueue is accepted at the first edge with rst low.

## Structure

- Shared package fetch_pkg:
  - typedef fetch_entry_t, a packed struct {instr, pc, pc_plus4}, each DATA_WIDTH wide
  - localparam PTR_W = $clog2(DEPTH)
- Storage is an array of fetch_entry_t inside the module. No sub-module; pointer and count logic is inline.
- Elaboration-time assertion: DEPTH is a power of two and ≥ 2.

## Test plan

- Reset then fill, DEPTH=4, out_ready=0: enqueue PCs 0x00,0x04,0x08,0x0C → count reaches 4, in_ready=0. A fifth in_valid is not accepted. out_pc=0x00 held stable.
- Drain in order, from full: out_ready=1 for 4 cycles → out_pc 0x00,0x04,0x08,0x0C on consecutive cycles, then out_valid=0, out_* = 0, count=0.
- Streaming: in_valid=out_ready=1 for 20 cycles, PCs incrementing by 4 from 0x100 → out_pc sequence identical, one per cycle after 1-cycle latency. Pointers wrap; count stays at 1.
- Simultaneous at full: count=4, out_ready=1, in_valid=1 → dequeue only, count=3. Next cycle, enqueue and dequeue together → count stays 3.
- Flush mid-stream: 3 entries queued, flush=1 with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0. Next enqueue of PC 0x200 appears as head.
- Reset mid-operation: 2 entries queued, rst=1 for one edge → all outputs at reset values. Queued entries never appear on out_*.
